// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared writeback-source codes, FSM states and stage record for hazard_ctrl
package hazard_ctrl_pkg;

  localparam logic [1:0] RegDst_FromALU = 2'd0;
  localparam logic [1:0] RegDst_FromMEM = 2'd1;
  localparam logic [1:0] RegDst_FromPC  = 2'd2;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hzState_t;

  typedef struct packed {
    logic       Mwk;
    logic       RegWr;
    logic [1:0] RegDst;
    logic [4:0] rd;
    logic [1:0] cmp;
  } stageInfo_t;

  // A load in EX whose result the ID instruction needs; the MEM-stage copy is always forwardable.
  function automatic logic loadUseHit(stageInfo_t pre, logic idValid,
                                      logic [4:0] rs1, logic useRs1,
                                      logic [4:0] rs2, logic useRs2);
    logic srcMatch;
    srcMatch = (useRs1 && (rs1 == pre.rd)) || (useRs2 && (rs2 == pre.rd));
    return idValid && pre.Mwk && pre.RegWr && (pre.RegDst == RegDst_FromMEM) &&
           (pre.rd != 5'd0) && srcMatch;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage request and hazard/forwarding response bundle
interface hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_RegWr;
  logic [1:0] id_RegDst;
  logic [4:0] id_rd;
  logic [1:0] id_cmp;
  logic       ex_taken;

  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_bubble;

  logic       preMwk;
  logic       preRegWr;
  logic [1:0] preRegDst;
  logic [4:0] prerd;
  logic [1:0] preCmp;
  logic       ppreMwk;
  logic       ppreRegWr;
  logic [1:0] ppreRegDst;
  logic [4:0] pprerd;
  logic [1:0] ppreCmp;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_RegWr, id_RegDst, id_rd,
           id_cmp, ex_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble,
           preMwk, preRegWr, preRegDst, prerd, preCmp,
           ppreMwk, ppreRegWr, ppreRegDst, pprerd, ppreCmp
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_RegWr, id_RegDst, id_rd,
           id_cmp, ex_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble,
           preMwk, preRegWr, preRegDst, prerd, preCmp,
           ppreMwk, ppreRegWr, ppreRegDst, pprerd, ppreCmp
  );
endinterface

// File: rtl/hazard_ctrl_pipe_tracker.sv
// rtl/hazard_ctrl_pipe_tracker.sv - two-deep EX/MEM instruction tracker with bubble insert
module pipe_tracker
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble,
  input  stageInfo_t idInfo,
  output stageInfo_t pre,
  output stageInfo_t ppre
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      ppre <= '0;
    end else begin
      ppre <= pre;
      pre  <= bubble ? '0 : idInfo;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage load-use stall / taken-branch squash controller
// Optional HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LU_STALL = 1
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W   = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] LuLoad = 2'(LU_STALL - 1);

  hzState_t   state, stateNext;
  logic [1:0] count, countNext;
  logic       luHit;
  logic       pcStall, ifidStall, ifidFlush, idexBubble;
  stageInfo_t idInfo, pre, ppre;

  assign idInfo = '{Mwk: hz.id_valid, RegWr: hz.id_RegWr, RegDst: hz.id_RegDst,
                    rd: hz.id_rd, cmp: hz.id_cmp};

  assign luHit = loadUseHit(pre, hz.id_valid, hz.id_rs1, hz.id_use_rs1,
                            hz.id_rs2, hz.id_use_rs2);

  pipe_tracker uTracker (
    .clk    (clk),
    .rst    (rst),
    .bubble (idexBubble),
    .idInfo (idInfo),
    .pre    (pre),
    .ppre   (ppre)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HZ_RUN;
      count <= 2'd0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      HZ_RUN: begin
        if (!hz.ex_taken && luHit) begin
          countNext = LuLoad;
          stateNext = (LuLoad != 2'd0) ? HZ_STALL : HZ_RUN;
        end
      end
      HZ_STALL: begin
        if (hz.ex_taken) begin
          countNext = 2'd0;
          stateNext = HZ_RUN;
        end else begin
          countNext = count - 2'd1;
          if (count == 2'd1) stateNext = HZ_RUN;
        end
      end
      default: stateNext = HZ_RUN;
    endcase
  end

  // A taken branch wins over any stall: the held ID instruction is on the wrong path anyway.
  always_comb begin
    pcStall    = 1'b0;
    ifidStall  = 1'b0;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    if (!rst) begin
      if (hz.ex_taken) begin
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
      end else if (state == HZ_STALL || luHit) begin
        pcStall    = 1'b1;
        ifidStall  = 1'b1;
        idexBubble = 1'b1;
      end
    end
  end

  assign hz.pc_stall    = pcStall;
  assign hz.ifid_stall  = ifidStall;
  assign hz.ifid_flush  = ifidFlush;
  assign hz.idex_bubble = idexBubble;

  assign hz.preMwk     = pre.Mwk;
  assign hz.preRegWr   = pre.RegWr;
  assign hz.preRegDst  = pre.RegDst;
  assign hz.prerd      = pre.rd;
  assign hz.preCmp     = pre.cmp;
  assign hz.ppreMwk    = ppre.Mwk;
  assign hz.ppreRegWr  = ppre.RegWr;
  assign hz.ppreRegDst = ppre.RegDst;
  assign hz.pprerd     = ppre.rd;
  assign hz.ppreCmp    = ppre.cmp;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pcStall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (ifidFlush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench: two DUTs (LU_STALL=1 and 3) against a behavioural model
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [1:0] dst;
    logic [4:0] rd;
    logic [1:0] cmp;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       idValid = 0, use1 = 0, use2 = 0, regWr = 0, exTaken = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [1:0] regDst = 0, cmp = 0;

  int errors = 0;
  int checks = 0;
  bit checkOn = 0;

  hazard_ctrl_if ifA ();
  hazard_ctrl_if ifB ();

  assign ifA.id_valid = idValid;  assign ifB.id_valid = idValid;
  assign ifA.id_rs1 = rs1;        assign ifB.id_rs1 = rs1;
  assign ifA.id_rs2 = rs2;        assign ifB.id_rs2 = rs2;
  assign ifA.id_use_rs1 = use1;   assign ifB.id_use_rs1 = use1;
  assign ifA.id_use_rs2 = use2;   assign ifB.id_use_rs2 = use2;
  assign ifA.id_RegWr = regWr;    assign ifB.id_RegWr = regWr;
  assign ifA.id_RegDst = regDst;  assign ifB.id_RegDst = regDst;
  assign ifA.id_rd = rd;          assign ifB.id_rd = rd;
  assign ifA.id_cmp = cmp;        assign ifB.id_cmp = cmp;
  assign ifA.ex_taken = exTaken;  assign ifB.ex_taken = exTaken;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCntA, flushCntA, stallCntB, flushCntB;
  hazard_ctrl #(.LU_STALL(1), .PERF_W(32)) dutA (.clk(clk), .rst(rst), .hz(ifA),
                                                 .stall_cnt(stallCntA), .flush_cnt(flushCntA));
  hazard_ctrl #(.LU_STALL(3), .PERF_W(32)) dutB (.clk(clk), .rst(rst), .hz(ifB),
                                                 .stall_cnt(stallCntB), .flush_cnt(flushCntB));
`else
  hazard_ctrl #(.LU_STALL(1)) dutA (.clk(clk), .rst(rst), .hz(ifA));
  hazard_ctrl #(.LU_STALL(3)) dutB (.clk(clk), .rst(rst), .hz(ifB));
`endif

  // Model: what is in EX/MEM, and how many forced stall cycles remain after this one.
  rec_t        mPre [2];
  rec_t        mPpre[2];
  int          mLeft[2];
  logic [31:0] mStall[2];
  logic [31:0] mFlush[2];
  int          luStall[2] = '{1, 3};

  // {pc_stall, ifid_stall, ifid_flush, idex_bubble}
  function automatic logic [3:0] expCtl(int k);
    logic needs;
    if (rst) return 4'b0000;
    if (exTaken) return 4'b0011;
    if (mLeft[k] > 0) return 4'b1101;
    needs = (use1 && rs1 == mPre[k].rd) || (use2 && rs2 == mPre[k].rd);
    if (idValid && mPre[k].v && mPre[k].wr && mPre[k].dst == RegDst_FromMEM &&
        mPre[k].rd != 5'd0 && needs) return 4'b1101;
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0] c;
      c = expCtl(k);
      if (rst) begin
        mPre[k] = '0; mPpre[k] = '0; mLeft[k] = 0; mStall[k] = 0; mFlush[k] = 0;
      end else begin
        mStall[k] = mStall[k] + {31'd0, c[3]};
        mFlush[k] = mFlush[k] + {31'd0, c[1]};
        mPpre[k]  = mPre[k];
        mPre[k]   = c[0] ? rec_t'(0) : rec_t'{idValid, regWr, regDst, rd, cmp};
        if (exTaken)        mLeft[k] = 0;
        else if (mLeft[k] > 0) mLeft[k] = mLeft[k] - 1;
        else if (c[3])      mLeft[k] = luStall[k] - 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      check("A.ctl", 64'({ifA.pc_stall, ifA.ifid_stall, ifA.ifid_flush, ifA.idex_bubble}), 64'(expCtl(0)));
      check("B.ctl", 64'({ifB.pc_stall, ifB.ifid_stall, ifB.ifid_flush, ifB.idex_bubble}), 64'(expCtl(1)));
      check("A.pre", 64'({ifA.preMwk, ifA.preRegWr, ifA.preRegDst, ifA.prerd, ifA.preCmp}), 64'(mPre[0]));
      check("B.pre", 64'({ifB.preMwk, ifB.preRegWr, ifB.preRegDst, ifB.prerd, ifB.preCmp}), 64'(mPre[1]));
      check("A.ppre", 64'({ifA.ppreMwk, ifA.ppreRegWr, ifA.ppreRegDst, ifA.pprerd, ifA.ppreCmp}), 64'(mPpre[0]));
      check("B.ppre", 64'({ifB.ppreMwk, ifB.ppreRegWr, ifB.ppreRegDst, ifB.pprerd, ifB.ppreCmp}), 64'(mPpre[1]));
      if (ifA.ifid_flush && ifA.ifid_stall) check("A.flush_and_stall", 64'd1, 64'd0);
`ifdef HAZARD_PERF_EN
      check("A.counts", {stallCntA, flushCntA}, {mStall[0], mFlush[0]});
      check("B.counts", {stallCntB, flushCntB}, {mStall[1], mFlush[1]});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic w, input logic [1:0] d, input logic [4:0] dr);
    idValid = v; rs1 = r1; use1 = u1; rs2 = r2; use2 = u2; regWr = w; regDst = d; rd = dr;
    cmp = 2'($urandom_range(0, 3));
  endtask

  task automatic ld(input logic [4:0] d);
    setId(1, 5'd0, 0, 5'd0, 0, 1, RegDst_FromMEM, d);
  endtask

  task automatic useRs1(input logic [4:0] r, input logic [4:0] d);
    setId(1, r, 1, 5'd0, 0, 1, RegDst_FromALU, d);
  endtask

  task automatic idle();
    setId(0, 5'd0, 0, 5'd0, 0, 0, RegDst_FromALU, 5'd0);
  endtask

  initial begin
    exTaken = 1;
    idle();
    step(); checkOn = 1;
    @(negedge clk);
    check("reset.flush_forced0", 64'(ifA.ifid_flush), 64'd0);
    check("reset.preMwk", 64'(ifA.preMwk), 64'd0);
    step(); rst = 0; exTaken = 0;

    // load-use on rs1: LU_STALL=1 stalls one cycle, LU_STALL=3 three
    ld(5'd5);
    step(); useRs1(5'd5, 5'd6);
    @(negedge clk);
    check("t1.A.stall", 64'(ifA.pc_stall), 64'd1);
    check("t1.B.stall", 64'(ifB.pc_stall), 64'd1);
    step();
    @(negedge clk);
    check("t1.A.released", 64'(ifA.pc_stall), 64'd0);
    check("t1.A.bubble_in_pre", 64'(ifA.preMwk), 64'd0);
    check("t1.B.still_stalled", 64'(ifB.pc_stall), 64'd1);
    step();
    @(negedge clk);
    check("t1.A.issued_rd", 64'(ifA.prerd), 64'd6);
    check("t1.B.third_stall", 64'(ifB.pc_stall), 64'd1);
    step();
    @(negedge clk);
    check("t1.B.released", 64'(ifB.pc_stall), 64'd0);

    // ALU producer is forwarded, never stalls
    step(); setId(1, 5'd0, 0, 5'd0, 0, 1, RegDst_FromALU, 5'd5);
    step(); setId(1, 5'd0, 0, 5'd5, 1, 0, RegDst_FromALU, 5'd0);
    @(negedge clk);
    check("t2.no_stall", 64'(ifA.pc_stall), 64'd0);
    check("t2.pre_dst_rd", 64'({ifA.preRegDst, ifA.prerd}), 64'({RegDst_FromALU, 5'd5}));

    // load into x0 never hazards
    step(); ld(5'd0);
    step(); useRs1(5'd0, 5'd1);
    @(negedge clk);
    check("t3.x0_no_stall", 64'(ifA.pc_stall), 64'd0);

    // invalid ID instruction never stalls
    step(); ld(5'd7);
    step(); setId(0, 5'd7, 1, 5'd7, 1, 0, RegDst_FromALU, 5'd0);
    @(negedge clk);
    check("invalid_id_no_stall", 64'(ifA.pc_stall), 64'd0);

    // match only in MEM stage is forwarded
    step(); ld(5'd8);
    step(); useRs1(5'd3, 5'd9);
    step(); useRs1(5'd8, 5'd10);
    @(negedge clk);
    check("ppre_match_no_stall", 64'(ifA.pc_stall), 64'd0);

    // taken branch in the second stall cycle aborts the LU_STALL=3 stall
    step(); idle();
    step(); ld(5'd5);
    step(); useRs1(5'd5, 5'd4);
    @(negedge clk);
    check("t4.B.stall1", 64'(ifB.pc_stall), 64'd1);
    step(); exTaken = 1;
    @(negedge clk);
    check("t4.B.ctl_abort", 64'({ifB.pc_stall, ifB.ifid_stall, ifB.ifid_flush, ifB.idex_bubble}), 64'b0011);
    step(); exTaken = 0; idle();
    @(negedge clk);
    check("t4.B.back_to_run", 64'(ifB.pc_stall), 64'd0);

    // ex_taken beats lu_hit in the same cycle
    step(); ld(5'd5);
    step(); useRs1(5'd5, 5'd11); exTaken = 1;
    @(negedge clk);
    check("t5.flush", 64'(ifA.ifid_flush), 64'd1);
    check("t5.no_stall", 64'(ifA.pc_stall), 64'd0);
    step(); exTaken = 0; idle();
    @(negedge clk);
    check("t5.pre_zeroed", 64'({ifA.preMwk, ifA.preRegWr, ifA.preRegDst, ifA.prerd, ifA.preCmp}), 64'd0);

    // reset in the middle of a stall
    step(); ld(5'd3);
    step(); useRs1(5'd3, 5'd12);
    step();
    @(negedge clk);
    check("rst.B.mid_stall", 64'(ifB.pc_stall), 64'd1);
    step(); rst = 1;
    @(negedge clk);
    check("rst.B.forced0", 64'(ifB.pc_stall), 64'd0);
    step(); rst = 0; idle();
    @(negedge clk);
    check("rst.B.run", 64'(ifB.pc_stall), 64'd0);

`ifdef HAZARD_PERF_EN
    step(); rst = 1;
    step(); rst = 0; ld(5'd5);
    step(); useRs1(5'd5, 5'd13);
    step();
    step(); ld(5'd6);
    step(); useRs1(5'd6, 5'd14);
    step();
    step(); idle(); exTaken = 1;
    step(); exTaken = 0;
    @(negedge clk);
    check("t6.A.stall_cnt", 64'(stallCntA), 64'd2);
    check("t6.A.flush_cnt", 64'(flushCntA), 64'd1);
    step(); rst = 1;
    step(); rst = 0;
    @(negedge clk);
    check("t6.A.cnt_reset", 64'({stallCntA, flushCntA}), 64'd0);
`endif

    step(); step();
    checkOn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
